grid_move_arbiter: RTL and testbench

Shares one saturating 4-bit move unit between two grid players, A and B, on a 16x16 grid. The block does three jobs:
- arbitrates step requests round-robin;
- sequences each granted request through a compute/commit pipeline;
- enforces that the two players never occupy the same cell.

It sits above the per-axis move datapath and owns both players' registered (x, y) positions.

---
 rtl/grid_move_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_grid_move_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/grid_move_arbiter.sv
// Round-robin arbiter sharing one saturating 4-bit move unit between two players on a 16x16 grid.
// Each grant runs IDLE -> CALC -> COMMIT -> DONE; a move that would land on the other player is rejected.
module grid_move_arbiter #(
    parameter int unsigned A_X0 = 0,
    parameter int unsigned A_Y0 = 0,
    parameter int unsigned B_X0 = 15,
    parameter int unsigned B_Y0 = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_a,
    input  logic [1:0] dir_a,
    input  logic [1:0] step_a,
    input  logic       req_b,
    input  logic [1:0] dir_b,
    input  logic [1:0] step_b,
    output logic       ack_a,
    output logic       ack_b,
    output logic       rej_a,
    output logic       rej_b,
    output logic [3:0] pos_a_x,
    output logic [3:0] pos_a_y,
    output logic [3:0] pos_b_x,
    output logic [3:0] pos_b_y,
    output logic       busy
);

    localparam int unsigned CW = 4;
    localparam int unsigned SW = CW + 1;
    localparam logic [CW-1:0] MAXV = CW'(15);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CALC   = 2'd1,
        S_COMMIT = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic            ptr_q, ptr_d;          // 0: A has priority, 1: B has priority
    logic            sel_q, sel_d;          // granted player, 0: A, 1: B
    logic [1:0]      dir_q, dir_d;
    logic [1:0]      step_q, step_d;
    logic [CW-1:0]   cur_x_q, cur_x_d, cur_y_q, cur_y_d;
    logic [CW-1:0]   tgt_x_q, tgt_x_d, tgt_y_q, tgt_y_d;
    logic [CW-1:0]   pa_x_q, pa_x_d, pa_y_q, pa_y_d;
    logic [CW-1:0]   pb_x_q, pb_x_d, pb_y_q, pb_y_d;
    logic            ack_a_q, ack_a_d, ack_b_q, ack_b_d;
    logic            rej_a_q, rej_a_d, rej_b_q, rej_b_d;
    logic            busy_q, busy_d;

    logic [CW-1:0]   axis_pos;
    logic [SW-1:0]   sum_w, dif_w;
    logic [CW-1:0]   moved;
    logic [CW-1:0]   oth_x, oth_y;

    // Shared move unit: 5-bit add/subtract, clamped to 0..15 via the carry/borrow bit.
    always_comb begin
        axis_pos = dir_q[1] ? cur_y_q : cur_x_q;
        sum_w    = {1'b0, axis_pos} + SW'(step_q);
        dif_w    = {1'b0, axis_pos} - SW'(step_q);
        if (!dir_q[0]) begin
            moved = sum_w[CW] ? MAXV : sum_w[CW-1:0];
        end else begin
            moved = dif_w[CW] ? '0 : dif_w[CW-1:0];
        end
    end

    assign oth_x = sel_q ? pa_x_q : pb_x_q;
    assign oth_y = sel_q ? pa_y_q : pb_y_q;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        dir_d   = dir_q;
        step_d  = step_q;
        cur_x_d = cur_x_q;
        cur_y_d = cur_y_q;
        tgt_x_d = tgt_x_q;
        tgt_y_d = tgt_y_q;
        pa_x_d  = pa_x_q;
        pa_y_d  = pa_y_q;
        pb_x_d  = pb_x_q;
        pb_y_d  = pb_y_q;
        ack_a_d = 1'b0;
        ack_b_d = 1'b0;
        rej_a_d = 1'b0;
        rej_b_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req_a || req_b) begin
                    sel_d   = req_b && (!req_a || ptr_q);
                    ptr_d   = !sel_d;
                    dir_d   = sel_d ? dir_b  : dir_a;
                    step_d  = sel_d ? step_b : step_a;
                    cur_x_d = sel_d ? pb_x_q : pa_x_q;
                    cur_y_d = sel_d ? pb_y_q : pa_y_q;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                tgt_x_d = dir_q[1] ? cur_x_q : moved;
                tgt_y_d = dir_q[1] ? moved   : cur_y_q;
                state_d = S_COMMIT;
            end
            S_COMMIT: begin
                if ((tgt_x_q == oth_x) && (tgt_y_q == oth_y)) begin
                    rej_a_d = !sel_q;
                    rej_b_d = sel_q;
                end else if (sel_q) begin
                    pb_x_d  = tgt_x_q;
                    pb_y_d  = tgt_y_q;
                    ack_b_d = 1'b1;
                end else begin
                    pa_x_d  = tgt_x_q;
                    pa_y_d  = tgt_y_q;
                    ack_a_d = 1'b1;
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            ptr_q   <= 1'b0;
            sel_q   <= 1'b0;
            dir_q   <= 2'd0;
            step_q  <= 2'd0;
            cur_x_q <= '0;
            cur_y_q <= '0;
            tgt_x_q <= '0;
            tgt_y_q <= '0;
            pa_x_q  <= CW'(A_X0);
            pa_y_q  <= CW'(A_Y0);
            pb_x_q  <= CW'(B_X0);
            pb_y_q  <= CW'(B_Y0);
            ack_a_q <= 1'b0;
            ack_b_q <= 1'b0;
            rej_a_q <= 1'b0;
            rej_b_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            dir_q   <= dir_d;
            step_q  <= step_d;
            cur_x_q <= cur_x_d;
            cur_y_q <= cur_y_d;
            tgt_x_q <= tgt_x_d;
            tgt_y_q <= tgt_y_d;
            pa_x_q  <= pa_x_d;
            pa_y_q  <= pa_y_d;
            pb_x_q  <= pb_x_d;
            pb_y_q  <= pb_y_d;
            ack_a_q <= ack_a_d;
            ack_b_q <= ack_b_d;
            rej_a_q <= rej_a_d;
            rej_b_q <= rej_b_d;
            busy_q  <= busy_d;
        end
    end

    assign ack_a   = ack_a_q;
    assign ack_b   = ack_b_q;
    assign rej_a   = rej_a_q;
    assign rej_b   = rej_b_q;
    assign pos_a_x = pa_x_q;
    assign pos_a_y = pa_y_q;
    assign pos_b_x = pb_x_q;
    assign pos_b_y = pb_y_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_grid_move_arbiter.sv
// Scoreboard bench for grid_move_arbiter: a grid/round-robin reference model predicts each response,
// and a negedge monitor pops and compares whenever ack or rej appears.
module tb_grid_move_arbiter;

    localparam int unsigned AX0 = 0;
    localparam int unsigned AY0 = 0;
    localparam int unsigned BX0 = 15;
    localparam int unsigned BY0 = 15;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_a = 1'b0, req_b = 1'b0;
    logic [1:0] dir_a = 2'd0, step_a = 2'd0, dir_b = 2'd0, step_b = 2'd0;
    logic       ack_a, ack_b, rej_a, rej_b, busy;
    logic [3:0] pos_a_x, pos_a_y, pos_b_x, pos_b_y;

    always #5 clk = ~clk;

    grid_move_arbiter #(.A_X0(AX0), .A_Y0(AY0), .B_X0(BX0), .B_Y0(BY0)) dut (
        .clk(clk), .rst(rst),
        .req_a(req_a), .dir_a(dir_a), .step_a(step_a),
        .req_b(req_b), .dir_b(dir_b), .step_b(step_b),
        .ack_a(ack_a), .ack_b(ack_b), .rej_a(rej_a), .rej_b(rej_b),
        .pos_a_x(pos_a_x), .pos_a_y(pos_a_y), .pos_b_x(pos_b_x), .pos_b_y(pos_b_y),
        .busy(busy)
    );

    typedef struct {
        int pl;
        int ack;
        int ax, ay, bx, by;
        int due;
    } exp_t;

    exp_t q_exp[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   mx[2], my[2];
    int   mptr;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void model_reset();
        mx[0] = AX0; my[0] = AY0;
        mx[1] = BX0; my[1] = BY0;
        mptr  = 0;
    endfunction

    // Grid rules: clamp to 0..15 on the chosen axis, reject if landing on the other player.
    function automatic void model_move(input int p, input int d, input int s, input int due);
        int   nx, ny, v;
        exp_t e;
        nx = mx[p];
        ny = my[p];
        v  = (d >= 2) ? ny : nx;
        if ((d % 2) == 0) v = (v + s > 15) ? 15 : v + s;
        else              v = (v - s < 0)  ? 0  : v - s;
        if (d >= 2) ny = v; else nx = v;
        e.pl  = p;
        e.ack = (nx == mx[1-p] && ny == my[1-p]) ? 0 : 1;
        if (e.ack == 1) begin
            mx[p] = nx;
            my[p] = ny;
        end
        e.ax = mx[0]; e.ay = my[0]; e.bx = mx[1]; e.by = my[1];
        e.due = due;
        q_exp.push_back(e);
    endfunction

    always @(negedge clk) begin
        if (!rst && (ack_a || ack_b || rej_a || rej_b)) begin
            chk("one_resp", int'(ack_a) + int'(ack_b) + int'(rej_a) + int'(rej_b), 1);
            if (q_exp.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp: got ack_a=%0d ack_b=%0d rej_a=%0d rej_b=%0d required none",
                         ack_a, ack_b, rej_a, rej_b);
            end else begin
                mon_e = q_exp.pop_front();
                chk("resp_player", (ack_b || rej_b) ? 1 : 0, mon_e.pl);
                chk("resp_ack", (ack_a || ack_b) ? 1 : 0, mon_e.ack);
                chk("resp_cycle", cyc, mon_e.due);
                chk("pos_a_x", pos_a_x, mon_e.ax);
                chk("pos_a_y", pos_a_y, mon_e.ay);
                chk("pos_b_x", pos_b_x, mon_e.bx);
                chk("pos_b_y", pos_b_y, mon_e.by);
                chk("resp_busy", busy, 1);
            end
        end
    end

    // One arbitration round issued at a negedge in IDLE; optionally scrambles dir/step once granted.
    task automatic round(input bit ra, input bit rb, input logic [1:0] da, input logic [1:0] sa,
                         input logic [1:0] db, input logic [1:0] sb, input bit scramble);
        int n, f, issue;
        for (int i = 0; i < 20 && busy; i++) @(negedge clk);
        n = int'(ra) + int'(rb);
        if (n == 0) return;
        issue = cyc;
        if (ra && rb) begin
            f = mptr;
            model_move(f, f ? int'(db) : int'(da), f ? int'(sb) : int'(sa), issue + 3);
            model_move(1 - f, f ? int'(da) : int'(db), f ? int'(sa) : int'(sb), issue + 7);
        end else if (ra) begin
            model_move(0, int'(da), int'(sa), issue + 3);
            mptr = 1;
        end else begin
            model_move(1, int'(db), int'(sb), issue + 3);
            mptr = 0;
        end
        req_a = ra; dir_a = da; step_a = sa;
        req_b = rb; dir_b = db; step_b = sb;
        for (int k = 1; k <= 4 * n; k++) begin
            @(negedge clk);
            chk("busy", busy, (k % 4) != 0 ? 1 : 0);
            if (ack_a || rej_a) req_a = 1'b0;
            if (ack_b || rej_b) req_b = 1'b0;
            if (k == 1 && scramble && n == 1) begin
                dir_a = 2'($urandom); step_a = 2'($urandom);
                dir_b = 2'($urandom); step_b = 2'($urandom);
            end
        end
        chk("drain", q_exp.size(), 0);
        if (req_a || req_b) begin
            req_a = 1'b0;
            req_b = 1'b0;
            repeat (8) @(negedge clk);
            q_exp.delete();
        end
    endtask

    task automatic single(input int p, input int d, input int s);
        if (p == 0) round(1'b1, 1'b0, 2'(d), 2'(s), 2'd0, 2'd0, 1'b0);
        else        round(1'b0, 1'b1, 2'd0, 2'd0, 2'(d), 2'(s), 1'b0);
    endtask

    // Walk a player toward (tx, ty), x axis first, using the model's view of its position.
    task automatic goto_cell(input int p, input int tx, input int ty);
        int dx, dy;
        for (int i = 0; i < 14; i++) begin
            dx = tx - mx[p];
            dy = ty - my[p];
            if (dx > 0)      single(p, 0, dx > 3 ? 3 : dx);
            else if (dx < 0) single(p, 1, -dx > 3 ? 3 : -dx);
            else if (dy > 0) single(p, 2, dy > 3 ? 3 : dy);
            else if (dy < 0) single(p, 3, -dy > 3 ? 3 : -dy);
            else break;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_pos_a_x", pos_a_x, AX0);
        chk("rst_pos_a_y", pos_a_y, AY0);
        chk("rst_pos_b_x", pos_b_x, BX0);
        chk("rst_pos_b_y", pos_b_y, BY0);
        chk("rst_busy", busy, 0);
        chk("rst_resp", int'(ack_a) + int'(ack_b) + int'(rej_a) + int'(rej_b), 0);
        rst = 1'b0;
        @(negedge clk);

        single(0, 0, 3);
        goto_cell(0, 14, 0);
        single(0, 0, 3);
        goto_cell(1, 10, 1);
        single(1, 3, 3);

        goto_cell(0, 5, 5);
        goto_cell(1, 7, 5);
        single(0, 0, 2);

        // Abort an A move in COMMIT with reset.
        req_a = 1'b1; dir_a = 2'd0; step_a = 2'd2;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_pos_a_x", pos_a_x, AX0);
        chk("abort_pos_a_y", pos_a_y, AY0);
        chk("abort_pos_b_x", pos_b_x, BX0);
        chk("abort_pos_b_y", pos_b_y, BY0);
        chk("abort_busy", busy, 0);
        chk("abort_resp", int'(ack_a) + int'(rej_a), 0);
        req_a = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        round(1'b1, 1'b1, 2'd0, 2'd1, 2'd1, 2'd2, 1'b0);
        single(0, 2, 1);
        round(1'b1, 1'b1, 2'd2, 2'd3, 2'd3, 2'd1, 1'b0);

        round(1'b1, 1'b0, 2'd0, 2'd2, 2'd0, 2'd0, 1'b1);
        round(1'b0, 1'b1, 2'd1, 2'd3, 2'd0, 2'd0, 1'b1);
        single(0, 1, 0);
        single(1, 2, 0);

        for (int r = 0; r < 150; r++) begin
            int kind;
            kind = int'($urandom_range(0, 2));
            round(kind != 1, kind != 0, 2'($urandom), 2'($urandom), 2'($urandom), 2'($urandom),
                  1'($urandom));
        end

        repeat (4) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
